rf_wb_scheduler: RTL and testbench
==================================

# rf_wb_scheduler

Register-file write-port scheduler and scoreboard for the 64-bit RV core. It arbitrates the single regfile write port between the single-cycle ALU writeback and the long-latency LSU writeback, and drives a registered write into the regfile. It also tracks one pending-write busy bit per architectural register and gates decode issue on RAW/WAW hazards, so only one write to any register can be in flight at a time.

## Interface
- XLEN, 64, data width of writeback and regfile write data.
- STARVE_MAX, 4, consecutive LSU-denied cycles before ALU-destined issue is held off (range 1..15).

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- id_valid  in  1  decode has an instruction to issue
- id_rs1 / id_rs2  in  5 each  source register indices
- id_rs1_en / id_rs2_en  in  1 each  source actually read
- id_rd  in  5  destination index
- id_rd_en  in  1  instruction writes rd
- id_long  in  1  rd is written by the LSU (else by the ALU)
- id_ready  out  1  issue permitted; issue occurs when id_valid & id_ready
- alu_valid  in  1  ALU writeback valid; no backpressure, always consumed
- alu_rd  in  5  ALU writeback destination
- alu_data  in  XLEN  ALU writeback data
- lsu_valid  in  1  LSU writeback valid
- lsu_rd  in  5  LSU writeback destination
- lsu_data  in  XLEN  LSU writeback data
- lsu_ready  out  1  LSU writeback accepted this cycle
- rf_we  out  1  regfile write enable (registered)
- rf_waddr  out  5  regfile write address (registered)
- rf_wdata  out  XLEN  regfile write data (registered)
- busy  out  32  scoreboard bits; bit 0 always 0
- err  out  1  sticky: writeback to a non-busy register

## Operation
- ALU slot occupied = alu_valid & (alu_rd != 0).
- lsu_ready = ~(ALU slot occupied); combinational.
- An LSU beat is granted when lsu_valid & lsu_ready.
- A consumed writeback with rd == 0 is dropped: no rf_we, no err.
- Next-cycle write port: the ALU if its slot is occupied; else the LSU if granted with lsu_rd != 0; else rf_we = 0. rf_waddr/rf_wdata load only when rf_we loads 1; otherwise they hold.
- Scoreboard clear: busy[r] clears in the cycle rf_we = 1 and rf_waddr = r.
- Scoreboard set: busy[id_rd] sets on issue when id_rd_en and id_rd != 0.
- Set and clear of the same register in the same cycle: set wins.
- Effective busy for hazard checks: eb[r] = busy[r] & ~(rf_we & rf_waddr == r). This relies on the regfile's same-cycle write-through bypass.
- Hazard: (id_rs1_en & eb[id_rs1]) | (id_rs2_en & eb[id_rs2]) | (id_rd_en & eb[id_rd]). Index 0 is never a hazard.
- Starvation counter (4 bits):
  - Increments each cycle lsu_valid & ~lsu_ready, saturating at STARVE_MAX.
  - Clears to 0 on an LSU grant or when lsu_valid = 0.
  - hold = (counter == STARVE_MAX).
- id_ready = ~hazard & ~(hold & id_rd_en & ~id_long).
- err sets when a consumed writeback with rd != 0 targets a register whose busy bit is 0 at arbitration time. err clears only on reset.

## Timing
- Reset values: busy 0, rf_we 0, rf_waddr 0, rf_wdata 0, err 0, starvation counter 0.
- Reset mid-operation discards all pending writes and scoreboard state.
- Writeback latency: source beat in cycle t produces rf_we in cycle t+1. busy clears at the end of t+1.
- A dependent instruction may issue in cycle t+1, reading the bypassed value.
- id_ready and lsu_ready are combinational from inputs and state. There is no combinational path from id_valid to lsu_ready.
- The LSU must hold lsu_valid/rd/data stable until lsu_ready.
- After hold asserts, the ALU pipeline drains, alu_valid falls, and the LSU is granted on the first cycle with no occupied ALU slot. The counter then returns to 0.

## Test plan
- Back-to-back RAW: issue rd=x5 (ALU). id_ready = 0 for rs1=x5 until the ALU beat for x5; rf_we=1, rf_waddr=5 one cycle later; the dependent instruction issues that same cycle; busy[5] = 0 afterwards.
- Collision: alu_valid (rd=3) and lsu_valid (rd=7) in the same cycle -> lsu_ready = 0, write x3 in the next cycle. In the following cycle, with no ALU beat, lsu_ready = 1 and the x7 write follows.
- x0 handling: issue with rd=0 -> busy stays 0. alu_valid with rd=0 and lsu_valid with rd=9 in the same cycle -> LSU granted, rf_waddr = 9, err = 0.
- Starvation: lsu_valid held while alu_valid with rd≠0 for 4 cycles -> hold asserts, an ALU-destined issue sees id_ready = 0 while an id_long issue with no hazard still issues. When the ALU stream stops, the LSU is granted and hold drops.
- WAW and simultaneous set/clear: x4 busy -> issue with rd=4 blocked. In the rf_we write cycle for x4, a new rd=4 issue proceeds and busy[4] remains 1.
- Error and reset: LSU writeback to non-busy x12 -> err = 1 and stays set. Assert rst_n low with busy bits set and rf_we pending -> all outputs return to 0 on the next clock.

Source files
------------

// File: rtl/rf_wb_scheduler.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | rf_wb_scheduler: regfile write-port arbiter (ALU over LSU, with LSU        |
// | starvation relief) and per-register pending-write scoreboard.             |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module rf_wb_scheduler #(
  parameter int XLEN       = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_rs1_en,
  input  logic            id_rs2_en,
  input  logic [4:0]      id_rd,
  input  logic            id_rd_en,
  input  logic            id_long,
  output logic            id_ready,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [31:0]     busy,
  output logic            err
);

  localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

  logic            r_rf_we;
  logic [4:0]      r_rf_waddr;
  logic [XLEN-1:0] r_rf_wdata;
  logic [31:0]     r_busy;
  logic [3:0]      r_starve;
  logic            r_err;

  logic            w_alu_occ;
  logic            w_lsu_grant;
  logic            w_lsu_wr;
  logic            w_wr_en;
  logic [4:0]      w_wr_addr;
  logic [XLEN-1:0] w_wr_data;
  logic            w_err_set;
  logic [31:0]     w_clr_mask;
  logic [31:0]     w_set_mask;
  logic [31:0]     w_eb;
  logic            w_hazard;
  logic            w_hold;
  logic            w_issue;

  // Arbitration: an occupied ALU slot always wins; an x0 ALU beat leaves the port free.
  assign w_alu_occ   = alu_valid & (alu_rd != 5'd0);
  assign lsu_ready   = ~w_alu_occ;
  assign w_lsu_grant = lsu_valid & ~w_alu_occ;
  assign w_lsu_wr    = w_lsu_grant & (lsu_rd != 5'd0);

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = alu_rd;
    w_wr_data = alu_data;
    w_err_set = 1'b0;
    if (w_alu_occ) begin
      w_wr_en   = 1'b1;
      w_err_set = ~r_busy[alu_rd];
    end else if (w_lsu_wr) begin
      w_wr_en   = 1'b1;
      w_wr_addr = lsu_rd;
      w_wr_data = lsu_data;
      w_err_set = ~r_busy[lsu_rd];
    end
  end

  // The register being written this cycle is visible through the regfile bypass.
  always_comb begin
    w_clr_mask = '0;
    if (r_rf_we) w_clr_mask[r_rf_waddr] = 1'b1;
  end

  assign w_eb     = r_busy & ~w_clr_mask;
  assign w_hazard = (id_rs1_en & w_eb[id_rs1]) |
                    (id_rs2_en & w_eb[id_rs2]) |
                    (id_rd_en  & w_eb[id_rd]);
  assign w_hold   = (r_starve == c_STARVE_MAX);
  assign id_ready = ~w_hazard & ~(w_hold & id_rd_en & ~id_long);
  assign w_issue  = id_valid & id_ready;

  always_comb begin
    w_set_mask = '0;
    if (w_issue & id_rd_en & (id_rd != 5'd0)) w_set_mask[id_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= 5'd0;
      r_rf_wdata <= '0;
    end else begin
      r_rf_we <= w_wr_en;
      if (w_wr_en) begin
        r_rf_waddr <= w_wr_addr;
        r_rf_wdata <= w_wr_data;
      end
    end
  end

  // Set is applied after clear so a same-cycle reissue keeps the bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= ((r_busy & ~w_clr_mask) | w_set_mask) & 32'hFFFF_FFFE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_starve <= 4'd0;
    end else if (!lsu_valid || w_lsu_grant) begin
      r_starve <= 4'd0;
    end else if (r_starve != c_STARVE_MAX) begin
      r_starve <= r_starve + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  assign rf_we    = r_rf_we;
  assign rf_waddr = r_rf_waddr;
  assign rf_wdata = r_rf_wdata;
  assign busy     = r_busy;
  assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_scheduler.sv
`default_nettype none
// Bench for rf_wb_scheduler: directed test-plan scenarios then random traffic,
// checked against a register-level reference model and a write scoreboard.
module tb_rf_wb_scheduler;
  localparam int XLEN       = 64;
  localparam int STARVE_MAX = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            id_valid, id_rs1_en, id_rs2_en, id_rd_en, id_long;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic            id_ready;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [31:0]     busy;
  logic            err;

  rf_wb_scheduler #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
    .id_rd(id_rd), .id_rd_en(id_rd_en), .id_long(id_long), .id_ready(id_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: which registers have a write owed, what the port wrote
  // last cycle, the sticky error and how long the LSU has been refused.
  typedef struct packed { logic [4:0] addr; logic [XLEN-1:0] data; } wr_t;
  wr_t exp_q[$];
  bit  m_busy[32];
  bit  m_we = 0;
  int  m_waddr = 0;
  bit  m_err = 0;
  int  m_starve = 0;
  bit  last_granted = 0;
  bit  last_issue = 0;

  function automatic bit eff_busy(input int r);
    return (r != 0) && m_busy[r] && !(m_we && (m_waddr == r));
  endfunction

  // Called at negedge+1 with inputs settled; checks, advances the model, waits a cycle.
  task automatic step();
    bit alu_occ, grant, hz, rdy, hold, nwe;
    int naddr;
    logic [31:0] exp_busy;
    alu_occ = alu_valid && (alu_rd != 0);
    grant   = lsu_valid && !alu_occ;
    hz      = (id_rs1_en && eff_busy(int'(id_rs1))) || (id_rs2_en && eff_busy(int'(id_rs2))) ||
              (id_rd_en && eff_busy(int'(id_rd)));
    hold    = (m_starve >= STARVE_MAX);
    rdy     = !hz && !(hold && id_rd_en && !id_long);
    for (int r = 0; r < 32; r++) exp_busy[r] = m_busy[r];
    check("lsu_ready", 64'(lsu_ready), 64'(!alu_occ));
    check("id_ready", 64'(id_ready), 64'(rdy));
    check("busy", 64'(busy), 64'(exp_busy));
    check("err", 64'(err), 64'(m_err));
    last_granted = grant;
    last_issue   = id_valid && rdy;
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) m_busy[r] = 0;
      m_we = 0; m_waddr = 0; m_err = 0; m_starve = 0;
      exp_q.delete();
    end else begin
      nwe = 0; naddr = 0;
      if (alu_occ) begin
        exp_q.push_back('{alu_rd, alu_data});
        if (!m_busy[alu_rd]) m_err = 1;
        nwe = 1; naddr = int'(alu_rd);
      end else if (grant && lsu_rd != 0) begin
        exp_q.push_back('{lsu_rd, lsu_data});
        if (!m_busy[lsu_rd]) m_err = 1;
        nwe = 1; naddr = int'(lsu_rd);
      end
      if (m_we) m_busy[m_waddr] = 0;
      if (last_issue && id_rd_en && id_rd != 0) m_busy[id_rd] = 1;
      if (!lsu_valid || grant) m_starve = 0;
      else if (m_starve < STARVE_MAX) m_starve++;
      m_we = nwe; m_waddr = naddr;
    end
    @(negedge clk);
  endtask

  task automatic cyc();
    #1; step();
  endtask

  // Write-port monitor: each registered write must match the oldest expected one.
  logic [4:0]      mon_addr = '0;
  logic [XLEN-1:0] mon_data = '0;
  initial begin
    wr_t w;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        mon_addr = '0; mon_data = '0;
        check("rst_rf_we", 64'(rf_we), 64'd0);
        check("rst_rf_waddr", 64'(rf_waddr), 64'd0);
        check("rst_rf_wdata", rf_wdata, 64'd0);
      end else begin
        check("rf_we", 64'(rf_we), 64'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          mon_addr = w.addr; mon_data = w.data;
        end
        check("rf_waddr", 64'(rf_waddr), 64'(mon_addr));
        check("rf_wdata", rf_wdata, mon_data);
      end
    end
  end

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_en = 0; id_rs2_en = 0;
    id_rd = 0; id_rd_en = 0; id_long = 0;
    alu_valid = 0; alu_rd = 0; alu_data = '0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = '0;
  endtask

  task automatic id_set(input logic v, input logic [4:0] rs1, input logic e1,
                        input logic [4:0] rd, input logic rde, input logic lng);
    id_valid = v; id_rs1 = rs1; id_rs1_en = e1; id_rs2 = 0; id_rs2_en = 0;
    id_rd = rd; id_rd_en = rde; id_long = lng;
  endtask

  task automatic alu_set(input logic v, input logic [4:0] rd, input logic [XLEN-1:0] d);
    alu_valid = v; alu_rd = rd; alu_data = d;
  endtask

  task automatic lsu_set(input logic v, input logic [4:0] rd, input logic [XLEN-1:0] d);
    lsu_valid = v; lsu_rd = rd; lsu_data = d;
  endtask

  // Random-phase bookkeeping: who owes each busy register and whether its beat went out.
  bit sent[32];
  bit is_long[32];

  function automatic int pick(input bit want_long);
    int c[$];
    for (int r = 1; r < 32; r++)
      if (m_busy[r] && (is_long[r] == want_long) && !sent[r]) c.push_back(r);
    if (c.size() == 0) return 0;
    return c[$urandom_range(0, c.size() - 1)];
  endfunction

  initial begin
    int p;
    rst_n = 0;
    idle();
    @(negedge clk);
    cyc();
    rst_n = 1;

    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_we", 64'(rf_we), 64'd0);
    check("rst_waddr", 64'(rf_waddr), 64'd0);
    check("rst_wdata", rf_wdata, 64'd0);
    step();

    // Back-to-back RAW on x5
    id_set(1, 0, 0, 5, 1, 0); #1; check("raw_issue", 64'(id_ready), 64'd1); step();
    id_set(1, 5, 1, 0, 0, 0); #1; check("raw_blocked", 64'(id_ready), 64'd0); step();
    alu_set(1, 5, 64'hA5A5_0000_1234_5678); #1; check("raw_blocked_beat", 64'(id_ready), 64'd0); step();
    alu_set(0, 0, '0); #1;
    check("raw_we", 64'(rf_we), 64'd1);
    check("raw_waddr", 64'(rf_waddr), 64'd5);
    check("raw_bypass_issue", 64'(id_ready), 64'd1);
    step();
    idle(); #1; check("raw_busy5_clear", 64'(busy[5]), 64'd0); step();

    // ALU/LSU collision
    id_set(1, 0, 0, 3, 1, 0); cyc();
    id_set(1, 0, 0, 7, 1, 1); cyc();
    idle();
    alu_set(1, 3, 64'h3333); lsu_set(1, 7, 64'h7777);
    #1; check("coll_lsu_blocked", 64'(lsu_ready), 64'd0); step();
    alu_set(0, 0, '0);
    #1; check("coll_lsu_ready", 64'(lsu_ready), 64'd1); check("coll_w3", 64'(rf_waddr), 64'd3); step();
    lsu_set(0, 0, '0);
    #1; check("coll_w7", 64'(rf_waddr), 64'd7); check("coll_we", 64'(rf_we), 64'd1); step();

    // x0 handling
    id_set(1, 0, 0, 0, 1, 0); cyc();
    idle(); #1; check("x0_busy", 64'(busy), 64'd0); step();
    id_set(1, 0, 0, 9, 1, 1); cyc();
    idle(); alu_set(1, 0, 64'hDEAD); lsu_set(1, 9, 64'h9999);
    #1; check("x0_lsu_ready", 64'(lsu_ready), 64'd1); step();
    idle();
    #1; check("x0_waddr", 64'(rf_waddr), 64'd9); check("x0_wdata", rf_wdata, 64'h9999);
    check("x0_err", 64'(err), 64'd0); step();

    // Starvation: x10 on the LSU stuck behind six ALU writebacks
    id_set(1, 0, 0, 10, 1, 1); cyc();
    for (int k = 11; k <= 16; k++) begin id_set(1, 0, 0, 5'(k), 1, 0); cyc(); end
    idle();
    lsu_set(1, 10, 64'h1010);
    for (int k = 0; k < 4; k++) begin alu_set(1, 5'(11 + k), 64'(k)); cyc(); end
    alu_set(1, 15, 64'h15); id_set(1, 0, 0, 20, 1, 0);
    #1; check("starve_hold_alu", 64'(id_ready), 64'd0); check("starve_lsu_blocked", 64'(lsu_ready), 64'd0); step();
    alu_set(1, 16, 64'h16); id_set(1, 0, 0, 17, 1, 1);
    #1; check("starve_long_issue", 64'(id_ready), 64'd1); step();
    alu_set(0, 0, '0); id_set(1, 0, 0, 20, 1, 0);
    #1; check("starve_grant", 64'(lsu_ready), 64'd1); check("starve_still_hold", 64'(id_ready), 64'd0); step();
    lsu_set(0, 0, '0);
    #1; check("starve_released", 64'(id_ready), 64'd1); check("starve_w10", 64'(rf_waddr), 64'd10); step();

    // WAW and simultaneous set/clear on x4
    id_set(1, 0, 0, 4, 1, 0); cyc();
    #1; check("waw_blocked", 64'(id_ready), 64'd0); step();
    alu_set(1, 4, 64'h4444); #1; check("waw_blocked_beat", 64'(id_ready), 64'd0); step();
    alu_set(0, 0, '0);
    #1; check("waw_write_cycle_ready", 64'(id_ready), 64'd1); check("waw_w4", 64'(rf_waddr), 64'd4); step();
    idle(); #1; check("waw_busy4", 64'(busy[4]), 64'd1); step();

    // Error on writeback to non-busy x12
    lsu_set(1, 12, 64'h1212); #1; check("err_pre", 64'(err), 64'd0); step();
    lsu_set(0, 0, '0); #1; check("err_set", 64'(err), 64'd1); step();
    cyc(); cyc();
    #1; check("err_sticky", 64'(err), 64'd1); step();

    // Reset with busy bits set and a write on the port
    alu_set(1, 4, 64'h4040); cyc();
    idle(); rst_n = 0;
    #1; check("rstm_we_pending", 64'(rf_we), 64'd1); check("rstm_busy_set", 64'(busy != 0), 64'd1); step();
    rst_n = 1;
    #1;
    check("rstm_busy", 64'(busy), 64'd0);
    check("rstm_err", 64'(err), 64'd0);
    check("rstm_we", 64'(rf_we), 64'd0);
    check("rstm_waddr", 64'(rf_waddr), 64'd0);
    check("rstm_wdata", rf_wdata, 64'd0);
    step();

    // Random traffic with legal writebacks
    for (int r = 0; r < 32; r++) begin sent[r] = 0; is_long[r] = 0; end
    for (int c = 0; c < 3000; c++) begin
      id_valid  = 1'($urandom_range(0, 1));
      id_rs1    = 5'($urandom_range(0, 7));
      id_rs2    = 5'($urandom_range(0, 7));
      id_rs1_en = 1'($urandom_range(0, 1));
      id_rs2_en = 1'($urandom_range(0, 1));
      id_rd     = 5'($urandom_range(0, 7));
      id_rd_en  = 1'($urandom_range(0, 3) != 0);
      id_long   = ($urandom_range(0, 2) == 0);
      alu_set(0, 0, {$urandom, $urandom});
      if ($urandom_range(0, 9) < 6) begin
        p = pick(0);
        if (p != 0) begin alu_valid = 1; alu_rd = 5'(p); sent[p] = 1; end
        else if ($urandom_range(0, 3) == 0) alu_valid = 1;
      end
      if (!(lsu_valid && !last_granted)) begin
        lsu_set(0, 0, {$urandom, $urandom});
        if ($urandom_range(0, 2) == 0) begin
          p = pick(1);
          if (p != 0) begin lsu_valid = 1; lsu_rd = 5'(p); sent[p] = 1; end
          else if ($urandom_range(0, 3) == 0) lsu_valid = 1;
        end
      end
      #1; step();
      if (last_issue && id_rd_en && id_rd != 0) begin
        is_long[id_rd] = id_long;
        sent[id_rd]    = 0;
      end
    end

    idle(); cyc(); cyc();
    #1; check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
